// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-expansion datapath: key-size
// encodings, the key-box FSM states and the byte-index type.
package aes_pkg;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    SUB  = 1'b1
  } state_t;

  typedef logic [1:0] byte_idx_t;

  // RotWord is skipped only on the AES-256 odd half-steps; AES-192 and the
  // reserved encoding both behave like AES-128 and always rotate.
  function automatic logic rot_needed(input logic [1:0] mode, input logic rd_lsb);
    logic rot_v;
    case (mode)
      MODE_128: rot_v = 1'b1;
      MODE_192: rot_v = 1'b1;
      MODE_256: rot_v = ~rd_lsb;
      default:  rot_v = 1'b1;
    endcase
    return rot_v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (x^254, which maps 0 to 0) followed by the FIPS-197 affine transform.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p_v;
    logic [7:0] x_v;
    p_v = 8'h00;
    x_v = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p_v = p_v ^ x_v;
      else      p_v = p_v;
      if (x_v[7]) x_v = {x_v[6:0], 1'b0} ^ 8'h1b;
      else        x_v = {x_v[6:0], 1'b0};
    end
    return p_v;
  endfunction

  // Inverse as a^254 through a short square-and-multiply chain.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2_v, x3_v, x6_v, x12_v, x15_v, x30_v, x60_v, x120_v, x240_v, x252_v;
    x2_v   = gf_mul(a, a);
    x3_v   = gf_mul(x2_v, a);
    x6_v   = gf_mul(x3_v, x3_v);
    x12_v  = gf_mul(x6_v, x6_v);
    x15_v  = gf_mul(x12_v, x3_v);
    x30_v  = gf_mul(x15_v, x15_v);
    x60_v  = gf_mul(x30_v, x30_v);
    x120_v = gf_mul(x60_v, x60_v);
    x240_v = gf_mul(x120_v, x120_v);
    x252_v = gf_mul(x240_v, x12_v);
    return gf_mul(x252_v, x2_v);
  endfunction

  // Affine step: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Pure lookup, no state.
  always_comb begin
    dout = affine(gf_inv(din));
  end

endmodule

// File: rtl/aes_key_box.sv
// Key-schedule word transformer: SubWord(RotWord(w)) or SubWord(w), using
// one shared S-box serially (one byte per cycle) behind start/valid.
// Rcon is applied downstream in aes_key_xor.
module aes_key_box
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [3:0]  RD,
  input  logic [31:0] word_in,
  output logic        busy,
  output logic        valid,
  output logic [31:0] keyBox_out
);

  state_t      state_r, state_s;
  byte_idx_t   idx_r, idx_s;
  logic [31:0] work_r, work_s;
  logic [31:0] res_r, res_s;
  logic [31:0] key_box_r, key_box_s;
  logic        valid_r, valid_s;
  logic        busy_r, busy_s;
  logic        rot_s;
  logic [7:0]  sbox_in_s;
  logic [7:0]  sbox_out_s;
  logic        unused_rd_s;

  // Only the round-index parity matters for the rotate decision.
  assign unused_rd_s = ^RD[3:1];

  // Byte 0 is the most significant byte (FIPS-197 order).
  function automatic logic [7:0] get_byte(input logic [31:0] w, input byte_idx_t i);
    logic [7:0] b_v;
    case (i)
      2'd0:    b_v = w[31:24];
      2'd1:    b_v = w[23:16];
      2'd2:    b_v = w[15:8];
      2'd3:    b_v = w[7:0];
      default: b_v = 8'h00;
    endcase
    return b_v;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input byte_idx_t i,
                                           input logic [7:0] b);
    logic [31:0] r_v;
    r_v = w;
    case (i)
      2'd0:    r_v[31:24] = b;
      2'd1:    r_v[23:16] = b;
      2'd2:    r_v[15:8]  = b;
      2'd3:    r_v[7:0]   = b;
      default: r_v = w;
    endcase
    return r_v;
  endfunction

  aes_sbox u_sbox (
    .din  (sbox_in_s),
    .dout (sbox_out_s)
  );

  // Select the working byte for the shared S-box and compute the rotate flag.
  always_comb begin
    sbox_in_s = get_byte(work_r, idx_r);
    rot_s     = rot_needed(mode, RD[0]);
  end

  // Next-state and datapath updates; keyBox_out only moves on completion.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    work_s    = work_r;
    res_s     = res_r;
    key_box_s = key_box_r;
    valid_s   = 1'b0;
    busy_s    = busy_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          work_s  = rot_s ? {word_in[23:0], word_in[31:24]} : word_in;
          idx_s   = 2'd0;
          busy_s  = 1'b1;
          state_s = SUB;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SUB: begin
        res_s = put_byte(res_r, idx_r, sbox_out_s);
        if (idx_r == 2'd3) begin
          key_box_s = res_s;
          valid_s   = 1'b1;
          busy_s    = 1'b0;
          idx_s     = 2'd0;
          state_s   = IDLE;
        end else begin
          idx_s     = idx_r + 2'd1;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 2'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      work_r    <= 32'h0000_0000;
      res_r     <= 32'h0000_0000;
      key_box_r <= 32'h0000_0000;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      work_r    <= work_s;
      res_r     <= res_s;
      key_box_r <= key_box_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
    end
  end

  assign busy       = busy_r;
  assign valid      = valid_r;
  assign keyBox_out = key_box_r;

endmodule
